// File: rtl/dbg_host_bridge_pkg.sv
// Shared debug-bus types, bridge opcodes/responses and the bridge FSM state type.
package dbg_host_bridge_pkg;

    typedef logic [7:0] byte_t;

    // Debug bus segments; the responder decodes ROM writes from segment alone.
    typedef enum logic [1:0] {
        CTL = 2'd0,
        ROM = 2'd1,
        RAM = 2'd2,
        CPU = 2'd3
    } seg_e;

    localparam int unsigned SEG_ADDR_W = 8;
    typedef logic [SEG_ADDR_W-1:0] seg_addr_t;

    typedef struct packed {
        seg_e      seg;
        seg_addr_t addr;
    } addr_t;

    localparam int unsigned ADDR_W = $bits(addr_t);

    localparam seg_addr_t Ctl_sys_rst_addr = 8'h01;

    localparam byte_t Op_wr    = 8'h57;
    localparam byte_t Op_rd    = 8'h52;
    localparam byte_t Op_burst = 8'h42;
    localparam byte_t Resp_ack = 8'h06;
    localparam byte_t Resp_nak = 8'h15;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        OPC  = 4'd1,
        AHI  = 4'd2,
        ALO  = 4'd3,
        LEN  = 4'd4,
        DATA = 4'd5,
        WR   = 4'd6,
        RD   = 4'd7,
        RESP = 4'd8
    } bridge_state_e;

    // States in which the inter-byte timeout runs.
    function automatic logic is_timed(input bridge_state_e s);
        return (s == AHI) || (s == ALO) || (s == LEN) || (s == DATA);
    endfunction

    // States in which a command byte can be accepted.
    function automatic logic takes_byte(input bridge_state_e s);
        return (s == OPC) || is_timed(s);
    endfunction

endpackage

// File: rtl/dbg_host_bridge_if.sv
// Host byte stream plus debug bus, seen from the bridge (master) and its environment (slave).
interface dbg_host_bridge_if
    import dbg_host_bridge_pkg::*;
;
    byte_t in_data;
    logic  in_valid;
    logic  in_ready;
    byte_t out_data;
    logic  out_valid;
    logic  out_ready;
    addr_t dbg_addr;
    logic  dbg_wen;
    byte_t dbg_wdata;
    byte_t dbg_rdata;

    modport master (
        input  in_data, in_valid, out_ready, dbg_rdata,
        output in_ready, out_data, out_valid, dbg_addr, dbg_wen, dbg_wdata
    );

    modport slave (
        output in_data, in_valid, out_ready, dbg_rdata,
        input  in_ready, out_data, out_valid, dbg_addr, dbg_wen, dbg_wdata
    );
endinterface

// File: rtl/dbg_host_bridge.sv
// Debug bus initiator: parses W/R/B commands from a host byte stream and answers one byte each.
module dbg_host_bridge
    import dbg_host_bridge_pkg::*;
#(
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned TIMEOUT   = 1000000,
    parameter addr_t       PARK_ADDR = '{seg: CTL, addr: '0}
) (
    input  logic              clk,
    input  logic              rst,
    dbg_host_bridge_if.master bus
);

    localparam int unsigned TW  = $clog2(TIMEOUT + 1);
    localparam int unsigned RCW = $clog2(RD_LAT + 1);
    localparam int unsigned AHW = ADDR_W - 8;

    bridge_state_e  state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [RCW-1:0] rd_cnt_q, rd_cnt_d;
    byte_t          cnt_q, cnt_d;
    byte_t          opc_q, opc_d;
    logic [AHW-1:0] ahi_q, ahi_d;
    addr_t          tgt_q, tgt_d;

    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    byte_t          out_data_q, out_data_d;
    addr_t          dbg_addr_q, dbg_addr_d;
    logic           dbg_wen_q, dbg_wen_d;
    byte_t          dbg_wdata_q, dbg_wdata_d;

    logic           acc;
    logic           expired;
    addr_t          alo_addr;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.dbg_addr  = dbg_addr_q;
    assign bus.dbg_wen   = dbg_wen_q;
    assign bus.dbg_wdata = dbg_wdata_q;

    assign acc      = bus.in_valid && in_ready_q;
    assign expired  = is_timed(state_q) && (timer_q == TW'(TIMEOUT - 1));
    assign alo_addr = addr_t'({ahi_q, bus.in_data});

    // Next-state and next-output decode for the command parser.
    always_comb begin
        state_d     = state_q;
        rd_cnt_d    = rd_cnt_q;
        cnt_d       = cnt_q;
        opc_d       = opc_q;
        ahi_d       = ahi_q;
        tgt_d       = tgt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        dbg_addr_d  = PARK_ADDR;
        dbg_wen_d   = 1'b0;
        dbg_wdata_d = dbg_wdata_q;
        timer_d     = '0;
        in_ready_d  = 1'b0;

        if (expired) begin
            // in_ready was held low this cycle, so nothing was accepted.
            state_d     = RESP;
            out_valid_d = 1'b1;
            out_data_d  = Resp_nak;
        end else begin
            case (state_q)
                IDLE: state_d = OPC;
                OPC: if (acc) begin
                    opc_d = bus.in_data;
                    if ((bus.in_data == Op_wr) || (bus.in_data == Op_rd) ||
                        (bus.in_data == Op_burst)) begin
                        state_d = AHI;
                    end else begin
                        state_d     = RESP;
                        out_valid_d = 1'b1;
                        out_data_d  = Resp_nak;
                    end
                end
                AHI: if (acc) begin
                    ahi_d   = bus.in_data[AHW-1:0];
                    state_d = ALO;
                end
                ALO: if (acc) begin
                    tgt_d = alo_addr;
                    if (opc_q == Op_burst) begin
                        state_d = LEN;
                    end else if (opc_q == Op_wr) begin
                        cnt_d   = '0;
                        state_d = DATA;
                    end else if (alo_addr.seg == ROM) begin
                        // ROM is write-only on this bus; refuse without a bus cycle.
                        state_d     = RESP;
                        out_valid_d = 1'b1;
                        out_data_d  = Resp_nak;
                    end else begin
                        state_d    = RD;
                        dbg_addr_d = alo_addr;
                        rd_cnt_d   = RCW'(RD_LAT - 1);
                    end
                end
                LEN: if (acc) begin
                    cnt_d   = bus.in_data;
                    state_d = DATA;
                end
                DATA: if (acc) begin
                    state_d     = WR;
                    dbg_addr_d  = tgt_q;
                    dbg_wen_d   = (tgt_q != PARK_ADDR);
                    dbg_wdata_d = bus.in_data;
                end
                WR: begin
                    if (cnt_q == '0) begin
                        state_d     = RESP;
                        out_valid_d = 1'b1;
                        out_data_d  = Resp_ack;
                    end else begin
                        cnt_d      = cnt_q - 8'd1;
                        tgt_d.addr = tgt_q.addr + seg_addr_t'(1);
                        state_d    = DATA;
                    end
                end
                RD: begin
                    if (rd_cnt_q == '0) begin
                        state_d     = RESP;
                        out_valid_d = 1'b1;
                        out_data_d  = bus.dbg_rdata;
                    end else begin
                        rd_cnt_d   = rd_cnt_q - RCW'(1);
                        dbg_addr_d = tgt_q;
                    end
                end
                RESP: if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        // Idle-cycle counter restarts on every state change (each accepted byte moves state).
        if (is_timed(state_d) && (state_d == state_q)) begin
            timer_d = timer_q + TW'(1);
        end

        // Drop in_ready ahead of the cycle on which the timeout will fire.
        in_ready_d = takes_byte(state_d) && !out_valid_d &&
                     !(is_timed(state_d) && (timer_d == TW'(TIMEOUT - 1)));
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            rd_cnt_q    <= '0;
            cnt_q       <= '0;
            opc_q       <= '0;
            ahi_q       <= '0;
            tgt_q       <= PARK_ADDR;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            dbg_addr_q  <= PARK_ADDR;
            dbg_wen_q   <= 1'b0;
            dbg_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            rd_cnt_q    <= rd_cnt_d;
            cnt_q       <= cnt_d;
            opc_q       <= opc_d;
            ahi_q       <= ahi_d;
            tgt_q       <= tgt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            dbg_addr_q  <= dbg_addr_d;
            dbg_wen_q   <= dbg_wen_d;
            dbg_wdata_q <= dbg_wdata_d;
        end
    end

endmodule

// File: tb/tb_dbg_host_bridge.sv
// Directed bench for dbg_host_bridge with a registered-read responder model.
module tb_dbg_host_bridge;
    import dbg_host_bridge_pkg::*;

    localparam addr_t PARK = '{seg: CTL, addr: '0};

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    dbg_host_bridge_if bus ();

    dbg_host_bridge #(
        .RD_LAT   (2),
        .TIMEOUT  (16),
        .PARK_ADDR(PARK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder: write on wen, registered read data.
    logic [7:0]        mem [0:1023];
    logic [ADDR_W-1:0] a_v;
    assign a_v = bus.dbg_addr;

    always @(posedge clk) begin
        if (bus.dbg_wen) mem[a_v] <= bus.dbg_wdata;
        bus.dbg_rdata <= mem[a_v];
    end

    // Bus monitor: logs writes, counts non-parked cycles and parked-address strobes.
    int                wen_cnt;
    int                addr_cnt;
    int                park_viol;
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [7:0]        wr_data_q[$];

    initial begin
        wen_cnt = 0;
        addr_cnt = 0;
        park_viol = 0;
    end

    always @(negedge clk) begin
        if (bus.dbg_wen) begin
            wen_cnt++;
            wr_addr_q.push_back(a_v);
            wr_data_q.push_back(bus.dbg_wdata);
            if (a_v == ADDR_W'(PARK)) park_viol++;
        end
        if (a_v != ADDR_W'(PARK)) addr_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("tx_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic recv_byte(input string tag, input logic [7:0] exp);
        int n;
        n = 0;
        bus.out_ready = 1'b1;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check_eq(tag, 32'(bus.out_data), 32'(exp));
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w0;
        int          a0;
        int          n;
        logic        stable;
        logic        rdy_lo;
        logic        rdy14;
        logic        rdy15;
        logic [7:0]  held;
        logic [ADDR_W-1:0] exp_a [4];

        n_checks = 0;
        n_fail   = 0;
        rst           = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);

        check_eq("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_out_data",  32'(bus.out_data),  32'd0);
        check_eq("rst_dbg_addr",  32'(bus.dbg_addr),  32'h000);
        check_eq("rst_dbg_wen",   32'(bus.dbg_wen),   32'd0);
        check_eq("rst_dbg_wdata", 32'(bus.dbg_wdata), 32'd0);
        rst = 1'b1;

        // Single write to CTL sys-rst, checking the one-cycle strobe and ACK latency.
        w0 = wen_cnt;
        send_byte(Op_wr); send_byte(8'h00); send_byte(8'h01); send_byte(8'h11);
        check_eq("wr_wen",      32'(bus.dbg_wen),   32'd1);
        check_eq("wr_addr",     32'(bus.dbg_addr),  32'h001);
        check_eq("wr_wdata",    32'(bus.dbg_wdata), 32'h11);
        check_eq("wr_early_ack", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check_eq("wr_wen_off",  32'(bus.dbg_wen),   32'd0);
        check_eq("wr_parked",   32'(bus.dbg_addr),  32'h000);
        check_eq("wr_ack_lat",  32'(bus.out_valid), 32'd1);
        recv_byte("wr_ack", Resp_ack);
        check_eq("wr_wen_count", 32'(wen_cnt - w0), 32'd1);

        // Read back with RD_LAT=2 timing, then hold off out_ready for 10 cycles.
        send_byte(Op_rd); send_byte(8'h00); send_byte(8'h01);
        check_eq("rd_addr0",  32'(bus.dbg_addr),  32'h001);
        check_eq("rd_valid0", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check_eq("rd_addr1",  32'(bus.dbg_addr),  32'h001);
        check_eq("rd_valid1", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check_eq("rd_valid2", 32'(bus.out_valid), 32'd1);
        check_eq("rd_parked", 32'(bus.dbg_addr),  32'h000);
        check_eq("rd_data",   32'(bus.out_data),  32'h11);
        held   = bus.out_data;
        stable = 1'b1;
        rdy_lo = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_data != held || !bus.out_valid) stable = 1'b0;
            if (bus.in_ready) rdy_lo = 1'b0;
        end
        check_eq("bp_stable",   32'(stable), 32'd1);
        check_eq("bp_in_ready", 32'(rdy_lo), 32'd1);
        recv_byte("rd_resp", 8'h11);

        // ROM burst of 4 wrapping 0xFE,0xFF,0x00,0x01 inside the segment.
        wr_addr_q.delete();
        wr_data_q.delete();
        a0 = addr_cnt;
        send_byte(Op_burst); send_byte(8'h01); send_byte(8'hFE); send_byte(8'h03);
        for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i));
        recv_byte("burst_ack", Resp_ack);
        exp_a[0] = 10'h1FE;
        exp_a[1] = 10'h1FF;
        exp_a[2] = 10'h100;
        exp_a[3] = 10'h101;
        check_eq("burst_count", 32'(wr_addr_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < wr_addr_q.size()) begin
                check_eq($sformatf("burst_addr%0d", i), 32'(wr_addr_q[i]), 32'(exp_a[i]));
                check_eq($sformatf("burst_data%0d", i), 32'(wr_data_q[i]), 32'(8'hA0 + 8'(i)));
            end
        end
        check_eq("burst_parked", 32'(addr_cnt - a0), 32'd4);
        repeat (3) @(negedge clk);
        check_eq("burst_one_ack", 32'(bus.out_valid), 32'd0);

        // Unknown opcode.
        w0 = wen_cnt;
        a0 = addr_cnt;
        send_byte(8'h00);
        recv_byte("badop_nak", Resp_nak);
        check_eq("badop_wen", 32'(wen_cnt - w0), 32'd0);
        check_eq("badop_addr", 32'(addr_cnt - a0), 32'd0);

        // Read from ROM is refused without touching the bus.
        a0 = addr_cnt;
        send_byte(Op_rd); send_byte(8'h01); send_byte(8'h10);
        recv_byte("romrd_nak", Resp_nak);
        check_eq("romrd_addr", 32'(addr_cnt - a0), 32'd0);

        // Timeout after 'W',AH: ready drops on the 16th idle cycle, NAK follows.
        w0 = wen_cnt;
        send_byte(Op_wr); send_byte(8'h00);
        n = 0;
        rdy14 = 1'b0;
        rdy15 = 1'b1;
        while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 14) rdy14 = bus.in_ready;
            if (n == 15) rdy15 = bus.in_ready;
        end
        check_eq("tmo_latency", 32'(n), 32'd16);
        check_eq("tmo_ready14", 32'(rdy14), 32'd1);
        check_eq("tmo_ready15", 32'(rdy15), 32'd0);
        recv_byte("tmo_nak", Resp_nak);
        check_eq("tmo_wen", 32'(wen_cnt - w0), 32'd0);
        send_byte(Op_rd); send_byte(8'h00); send_byte(8'h01);
        recv_byte("tmo_rd", 8'h11);

        // Reset during a RAM burst, right on the second write strobe.
        w0 = wen_cnt;
        send_byte(Op_burst); send_byte(8'h02); send_byte(8'h10); send_byte(8'h05);
        send_byte(8'h5A); send_byte(8'h5B);
        check_eq("mid_wen", 32'(bus.dbg_wen), 32'd1);
        #1 rst = 1'b0;
        #1;
        check_eq("mrst_in_ready",  32'(bus.in_ready),  32'd0);
        check_eq("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("mrst_out_data",  32'(bus.out_data),  32'd0);
        check_eq("mrst_dbg_addr",  32'(bus.dbg_addr),  32'h000);
        check_eq("mrst_dbg_wen",   32'(bus.dbg_wen),   32'd0);
        check_eq("mrst_dbg_wdata", 32'(bus.dbg_wdata), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("mrst_no_wen", 32'(wen_cnt - w0), 32'd2);
        check_eq("mrst_ready",  32'(bus.in_ready), 32'd1);
        send_byte(Op_rd); send_byte(8'h02); send_byte(8'h10);
        recv_byte("mrst_rd", 8'h5A);

        check_eq("park_wen", 32'(park_viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dbg_host_bridge.md
Name: dbg_host_bridge

Overview:
- Initiator (bus master) for the debug bus; the register/ROM side of that bus is the existing debug controller.
- Consumes a byte-stream command channel from the PS/host link and parses read, write and burst-write commands.
- Drives dbg_addr, dbg_wen and dbg_wdata, captures dbg_rdata, and returns one response byte per command.
- Used for ROM loading, reset sequencing and CPU state inspection.

Parameters:
- RD_LAT, 2: cycles from driving a read address to sampling dbg_rdata (the responder registers rdata).
- TIMEOUT, 1000000: idle cycles allowed between bytes of one command before it is aborted.
- PARK_ADDR, {dbg::CTL, '0}: value held on dbg_addr whenever no access is in progress.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- in_data  in  8  command byte (mcs4::byte_t).
- in_valid  in  1  in_data valid.
- in_ready  out  1  bridge accepts in_data this cycle.
- out_data  out  8  response byte.
- out_valid  out  1  response pending.
- out_ready  in  1  host consumes out_data.
- dbg_addr  out  $bits(dbg::addr_t)  debug bus address {seg, addr}.
- dbg_wen  out  1  write strobe.
- dbg_wdata  out  8  write data.
- dbg_rdata  in  8  read data from the responder.

Behaviour:
- Byte handshake: a byte transfers on a clk edge with valid&&ready. out_valid/out_data hold until out_ready.
- Reset values:
  - in_ready=0, out_valid=0, out_data=0.
  - dbg_addr=PARK_ADDR, dbg_wen=0, dbg_wdata=0.
  - state=IDLE, counters cleared.
- Reset asserted mid-command: the command is discarded and no bus cycle is issued after reset.
- Commands (first byte is the opcode; address is two bytes, hi then lo, and its low $bits(dbg::addr_t) bits are cast to dbg::addr_t):
  - 'W' (0x57) AH AL D: single write. Response ACK 0x06.
  - 'R' (0x52) AH AL: single read. Response is the read byte.
  - 'B' (0x42) AH AL N D0..DN: burst write of N+1 bytes (1..256). Addr field increments after each byte and wraps within dbg::seg_addr_t; seg is unchanged. One ACK after the last byte.
  - Any other opcode: NAK 0x15, back to IDLE, no bus activity.
- Read with seg==dbg::ROM: NAK and no bus cycle. The responder decodes ROM writes from segment alone, so only writes may target ROM.
- States:
  - IDLE -> OPC.
  - OPC -> AHI -> ALO.
  - ALO -> LEN (B only) -> DATA (W, B) -> WR.
  - ALO -> RD (R).
  - Every command ends in RESP -> IDLE.
- WR:
  - Exactly one cycle with dbg_addr=target, dbg_wdata=D, dbg_wen=1.
  - Next cycle dbg_addr returns to PARK_ADDR and dbg_wen=0.
  - In a burst, WR returns to DATA until all N+1 bytes are written.
- RD:
  - dbg_addr=target for RD_LAT cycles.
  - dbg_rdata is sampled on the RD_LAT-th edge and dbg_addr is parked on that edge.
- in_ready is 1 only in OPC/AHI/ALO/LEN/DATA and only when out_valid=0. It is 0 in WR, RD and RESP.
- Latency:
  - Last W byte accepted -> dbg_wen high on the next cycle -> ACK out_valid the cycle after.
  - R: out_valid RD_LAT+1 cycles after AL is accepted.
- Timeout:
  - A counter resets on every accepted byte and runs in AHI/ALO/LEN/DATA.
  - On reaching TIMEOUT, the bridge emits NAK and returns to IDLE. Already-written burst bytes remain written.
- Simultaneous events:
  - A byte arriving on the timeout cycle is dropped (in_ready=0 that cycle).
  - out_ready asserted while out_valid=0 is ignored.
- dbg_wen is never high while dbg_addr==PARK_ADDR.

Decomposition:
- dbg package additions:
  - Opcode constants Op_wr=8'h57, Op_rd=8'h52, Op_burst=8'h42.
  - Resp_ack=8'h06, Resp_nak=8'h15.
  - bridge_state_e enum.
- Reuse the existing dbg::addr_t, dbg::seg_addr_t and dbg::CTL/ROM.
- No sub-module: a single FSM plus timeout counter, burst counter and address register.

Test Plan:
- Write then read: 'W',{CTL,Ctl_sys_rst_addr},0x11, then 'R',{CTL,Ctl_sys_rst_addr}.
  - Response 0x06 to the write; the write is one dbg_wen cycle with wdata 0x11.
  - Read response equals the responder's rdata for that address (sys-rst readback).
- ROM burst: 'B',{ROM,0x0FE},N=3,{A0,A1,A2,A3}.
  - Four one-cycle writes to addr 0x0FE, 0x0FF, then wrapped per seg_addr_t width.
  - Single ACK; dbg_addr parked between writes.
- Bad opcode 0x00 -> NAK 0x15 and zero dbg_wen cycles.
- Read of a ROM address -> NAK 0x15; dbg_addr never leaves PARK_ADDR.
- Timeout: TIMEOUT=16, send 'W',AH then stall 16 cycles -> NAK; a following 'R' command still parses correctly.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles after 'R' -> out_data stable and in_ready=0 throughout.
  - Assert rst mid-burst -> all outputs return to reset values immediately, with no further dbg_wen.
